// File: rtl/soc_bus_pkg.sv
// Shared bus definitions: bridge FSM states, error read value and the data address map.
package soc_bus_pkg;

   localparam int unsigned ADDR_W   = 32;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned STRB_W   = DATA_W / 8;
   localparam int unsigned REGION_W = 12;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      WR_RESP,
      RD_ADDR,
      RD_DATA,
      RESP
   } bridge_state_t;

   localparam logic [DATA_W-1:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

   // Address map: region is selected by addr[31:20].
   localparam logic [REGION_W-1:0] IRAM_REGION   = 12'h001;
   localparam logic [REGION_W-1:0] DRAM_REGION   = 12'h002;
   localparam logic [REGION_W-1:0] PERIPH_REGION = 12'h100;

   // Region field of a byte address.
   function automatic logic [REGION_W-1:0] addr_region(input logic [ADDR_W-1:0] addr);
      return addr[ADDR_W-1 -: REGION_W];
   endfunction

   // True when the address falls in a decoded region.
   function automatic logic region_mapped(input logic [ADDR_W-1:0] addr);
      logic [REGION_W-1:0] r;
      r = addr_region(addr);
      return (r == IRAM_REGION) || (r == DRAM_REGION) || (r == PERIPH_REGION);
   endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// Response watchdog: counts busy cycles and flags the last allowed cycle.
module bus_timeout_ctr #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire_c
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count;

   // Count enabled cycles; clear has priority over enable.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + CNT_W'(1);
      end
   end

   assign expire_c = en && (count == LAST);

endmodule

// File: rtl/obi_axil_data_bridge.sv
// OBI data port to AXI-lite master bridge, one transaction in flight, with response watchdog.
module obi_axil_data_bridge
   import soc_bus_pkg::*;
#(
   parameter int unsigned        TIMEOUT_CYCLES = 256,
   parameter logic [DATA_W-1:0]  ERR_RDATA      = ERR_RDATA_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              data_req_i,
   output logic              data_gnt_o,
   input  logic              data_we_i,
   input  logic [STRB_W-1:0] data_be_i,
   input  logic [ADDR_W-1:0] data_addr_i,
   input  logic [DATA_W-1:0] data_wdata_i,
   output logic              data_rvalid_o,
   output logic [DATA_W-1:0] data_rdata_o,
   output logic              data_err_o,
   output logic [ADDR_W-1:0] m_awaddr,
   output logic              m_awvalid,
   input  logic              m_awready,
   output logic [DATA_W-1:0] m_wdata,
   output logic [STRB_W-1:0] m_wstrb,
   output logic              m_wvalid,
   input  logic              m_wready,
   input  logic              m_bvalid,
   output logic              m_bready,
   output logic [ADDR_W-1:0] m_araddr,
   output logic              m_arvalid,
   input  logic              m_arready,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_rvalid,
   output logic              m_rready
);

   bridge_state_t     state;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [STRB_W-1:0] be_q;
   logic              we_q;
   logic              aw_done;
   logic              w_done;

   logic aw_hs_c, w_hs_c, b_hs_c, r_hs_c;
   logic aw_fin_c, w_fin_c;
   logic tmo_en_c, tmo_clr_c, tmo_expire_c, abort_c;

   assign aw_hs_c  = m_awvalid && m_awready;
   assign w_hs_c   = m_wvalid && m_wready;
   assign b_hs_c   = m_bvalid && m_bready;
   assign r_hs_c   = m_rvalid && m_rready;
   assign aw_fin_c = aw_done || aw_hs_c;
   assign w_fin_c  = w_done || w_hs_c;

   assign tmo_en_c  = (state == WR) || (state == WR_RESP) ||
                      (state == RD_ADDR) || (state == RD_DATA);
   assign tmo_clr_c = (state == IDLE);
   // A B/R handshake on the expiry cycle completes normally.
   assign abort_c   = tmo_expire_c && !b_hs_c && !r_hs_c;

   // Only an idle bridge accepts a request; held requests wait for IDLE.
   assign data_gnt_o = !rst && data_req_i && (state == IDLE);

   // Address and payload stay stable for the whole transaction.
   assign m_awaddr = addr_q;
   assign m_araddr = addr_q;
   assign m_wdata  = wdata_q;
   assign m_wstrb  = be_q;

   bus_timeout_ctr #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_tmo (
      .clk      (clk),
      .rst      (rst),
      .clr      (tmo_clr_c),
      .en       (tmo_en_c),
      .expire_c (tmo_expire_c)
   );

   // Bridge FSM with registered channel controls and OBI response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         addr_q        <= '0;
         wdata_q       <= '0;
         be_q          <= '0;
         we_q          <= 1'b0;
         aw_done       <= 1'b0;
         w_done        <= 1'b0;
         m_awvalid     <= 1'b0;
         m_wvalid      <= 1'b0;
         m_bready      <= 1'b0;
         m_arvalid     <= 1'b0;
         m_rready      <= 1'b0;
         data_rvalid_o <= 1'b0;
         data_err_o    <= 1'b0;
         data_rdata_o  <= '0;
      end else if (abort_c) begin
         m_awvalid     <= 1'b0;
         m_wvalid      <= 1'b0;
         m_bready      <= 1'b0;
         m_arvalid     <= 1'b0;
         m_rready      <= 1'b0;
         data_rvalid_o <= 1'b1;
         data_err_o    <= 1'b1;
         data_rdata_o  <= we_q ? '0 : ERR_RDATA;
         state         <= RESP;
      end else begin
         case (state)
            IDLE: begin
               if (data_req_i) begin
                  addr_q  <= data_addr_i & 32'hFFFF_FFFC;
                  wdata_q <= data_wdata_i;
                  be_q    <= data_be_i;
                  we_q    <= data_we_i;
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
                  if (data_we_i) begin
                     m_awvalid <= 1'b1;
                     m_wvalid  <= 1'b1;
                     state     <= WR;
                  end else begin
                     m_arvalid <= 1'b1;
                     state     <= RD_ADDR;
                  end
               end
            end
            WR: begin
               if (aw_hs_c) m_awvalid <= 1'b0;
               if (w_hs_c)  m_wvalid  <= 1'b0;
               aw_done <= aw_fin_c;
               w_done  <= w_fin_c;
               if (aw_fin_c && w_fin_c) begin
                  m_bready <= 1'b1;
                  state    <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (b_hs_c) begin
                  m_bready      <= 1'b0;
                  data_rvalid_o <= 1'b1;
                  data_err_o    <= 1'b0;
                  data_rdata_o  <= '0;
                  state         <= RESP;
               end
            end
            RD_ADDR: begin
               if (m_arready) begin
                  m_arvalid <= 1'b0;
                  m_rready  <= 1'b1;
                  state     <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (r_hs_c) begin
                  m_rready      <= 1'b0;
                  data_rvalid_o <= 1'b1;
                  data_err_o    <= 1'b0;
                  data_rdata_o  <= m_rdata;
                  state         <= RESP;
               end
            end
            RESP: begin
               data_rvalid_o <= 1'b0;
               data_err_o    <= 1'b0;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_obi_axil_data_bridge.sv
// Directed and randomized checks of the OBI to AXI-lite data bridge against a memory model.
module tb_obi_axil_data_bridge;
   import soc_bus_pkg::*;

   localparam int unsigned TMO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        data_req_i, data_gnt_o, data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i, data_wdata_i;
   logic        data_rvalid_o, data_err_o;
   logic [31:0] data_rdata_o;
   logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
   logic [3:0]  m_wstrb;
   logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic        m_arvalid, m_arready, m_rvalid, m_rready;

   int errors = 0;
   int checks = 0;

   logic [31:0] model_mem [int];
   logic [31:0] slave_mem [int];

   obi_axil_data_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst),
      .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_we_i(data_we_i),
      .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
      .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
      .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready)
   );

   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got=%b exp=%b", tag, got, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   // One clock cycle; outputs are sampled 1ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic slave_idle();
      m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
      m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
   endtask

   function automatic logic [31:0] init_val(input int w);
      return 32'(w) ^ 32'hC0DE_0000;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_rd(input int w);
      return model_mem.exists(w) ? model_mem[w] : init_val(w);
   endfunction

   function automatic logic [31:0] slave_rd(input int w);
      return slave_mem.exists(w) ? slave_mem[w] : init_val(w);
   endfunction

   // One OBI transaction with a responsive slave (mapped) or a fake-ready, never-responding one.
   task automatic run_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd);
      logic        mapped, got, exp_err;
      logic [31:0] exp_rd;
      int          w, aw_w, w_w, b_w, ar_w, r_w;
      mapped = region_mapped(addr);
      w      = int'(addr >> 2);
      aw_w = int'($urandom_range(0, 3)); w_w = int'($urandom_range(0, 3));
      b_w  = int'($urandom_range(0, 3)); ar_w = int'($urandom_range(0, 3));
      r_w  = int'($urandom_range(0, 3));
      exp_err = !mapped;
      if (we) begin
         exp_rd = '0;
         if (mapped) model_mem[w] = merge(model_rd(w), wd, be);
      end else begin
         exp_rd = mapped ? model_rd(w) : ERR_RDATA_DEFAULT;
      end
      step();
      slave_idle();
      data_req_i = 1'b1; data_we_i = we; data_addr_i = addr; data_be_i = be; data_wdata_i = wd;
      #1;
      chk1("txn_gnt", data_gnt_o, 1'b1);
      chk1("txn_idle_rvalid", data_rvalid_o, 1'b0);
      got = 1'b0;
      for (int c = 1; c <= 40 && !got; c++) begin
         step();
         data_req_i = 1'b0;
         slave_idle();
         if (data_rvalid_o) begin
            got = 1'b1;
            chk32("txn_rdata", data_rdata_o, exp_rd);
            chk1("txn_err", data_err_o, exp_err);
            chk1("txn_m_quiet", m_awvalid | m_wvalid | m_bready | m_arvalid | m_rready, 1'b0);
            if (!mapped) chk32("txn_tmo_cycle", 32'(c), 32'(TMO + 1));
            else         chk1("txn_in_time", c <= int'(TMO), 1'b1);
         end else if (we) begin
            if (m_awvalid) begin
               if (!mapped || aw_w == 0) begin
                  m_awready = 1'b1;
                  if (mapped) chk32("txn_awaddr", m_awaddr, addr & 32'hFFFF_FFFC);
               end else aw_w--;
            end
            if (m_wvalid) begin
               if (!mapped || w_w == 0) begin
                  m_wready = 1'b1;
                  if (mapped) begin
                     chk32("txn_wstrb", 32'(m_wstrb), 32'(be));
                     slave_mem[w] = merge(slave_rd(w), m_wdata, m_wstrb);
                  end
               end else w_w--;
            end
            if (m_bready && mapped) begin
               if (b_w == 0) m_bvalid = 1'b1; else b_w--;
            end
         end else begin
            if (m_arvalid) begin
               if (!mapped || ar_w == 0) begin
                  m_arready = 1'b1;
                  if (mapped) chk32("txn_araddr", m_araddr, addr & 32'hFFFF_FFFC);
               end else ar_w--;
            end
            if (m_rready && mapped) begin
               if (r_w == 0) begin
                  m_rvalid = 1'b1;
                  m_rdata  = slave_rd(int'(m_araddr >> 2));
               end else r_w--;
            end
         end
      end
      chk1("txn_resp_seen", got, 1'b1);
   endtask

   initial begin
      logic [2:0]  r;
      logic [11:0] region;

      // Reset with a request pending: nothing granted, everything zero.
      rst = 1'b1;
      slave_idle();
      data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = '0; data_addr_i = '0; data_wdata_i = '0;
      step(); step();
      chk1("rst_gnt", data_gnt_o, 1'b0);
      chk1("rst_rvalid", data_rvalid_o, 1'b0);
      chk1("rst_valids", m_awvalid | m_wvalid | m_bready | m_arvalid | m_rready, 1'b0);
      chk32("rst_rdata", data_rdata_o, 32'h0);
      data_req_i = 1'b0;
      rst = 1'b0;
      step();

      // Zero-wait read.
      step(); data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h0020_0010; #1;
      chk1("rd_gnt_t0", data_gnt_o, 1'b1);
      step(); data_req_i = 1'b0;
      chk1("rd_arvalid_t1", m_arvalid, 1'b1);
      chk32("rd_araddr_t1", m_araddr, 32'h0020_0010);
      m_arready = 1'b1;
      step(); m_arready = 1'b0;
      chk1("rd_rready_t2", m_rready, 1'b1);
      m_rvalid = 1'b1; m_rdata = 32'h1234_5678;
      step(); slave_idle();
      chk1("rd_rvalid_t3", data_rvalid_o, 1'b1);
      chk32("rd_rdata_t3", data_rdata_o, 32'h1234_5678);
      chk1("rd_err_t3", data_err_o, 1'b0);
      step();
      chk1("rd_rvalid_t4", data_rvalid_o, 1'b0);

      // Write with W before AW and a late B.
      step(); data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h0010_0006;
      data_be_i = 4'b1100; data_wdata_i = 32'hAABB_0000; #1;
      chk1("wr_gnt_t0", data_gnt_o, 1'b1);
      step(); data_req_i = 1'b0;
      chk1("wr_awvalid_t1", m_awvalid, 1'b1);
      chk1("wr_wvalid_t1", m_wvalid, 1'b1);
      chk32("wr_awaddr_t1", m_awaddr, 32'h0010_0004);
      chk32("wr_wdata_t1", m_wdata, 32'hAABB_0000);
      chk32("wr_wstrb_t1", 32'(m_wstrb), 32'h0000_000C);
      m_wready = 1'b1;
      step(); m_wready = 1'b0;
      chk1("wr_wvalid_t2", m_wvalid, 1'b0);
      chk1("wr_awvalid_t2", m_awvalid, 1'b1);
      step();
      chk1("wr_awvalid_t3", m_awvalid, 1'b1);
      m_awready = 1'b1;
      step(); m_awready = 1'b0;
      chk1("wr_awvalid_t4", m_awvalid, 1'b0);
      chk1("wr_bready_t4", m_bready, 1'b1);
      chk32("wr_awaddr_t4", m_awaddr, 32'h0010_0004);
      step();
      chk32("wr_awaddr_t5", m_awaddr, 32'h0010_0004);
      chk1("wr_rvalid_t5", data_rvalid_o, 1'b0);
      m_bvalid = 1'b1;
      step(); m_bvalid = 1'b0;
      chk1("wr_rvalid_t6", data_rvalid_o, 1'b1);
      chk1("wr_err_t6", data_err_o, 1'b0);
      chk32("wr_rdata_t6", data_rdata_o, 32'h0);

      // Watchdog aborts, then a normal read.
      run_txn(1'b1, 32'h3000_0000, 4'hF, 32'h0BAD_F00D);
      run_txn(1'b0, 32'h3000_0000, 4'h0, 32'h0);
      run_txn(1'b0, 32'h0020_0010, 4'h0, 32'h0);

      // Request held across two back-to-back reads.
      step(); slave_idle();
      data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h0010_0000; #1;
      chk1("b2b_gnt_t0", data_gnt_o, 1'b1);
      step(); chk1("b2b_gnt_t1", data_gnt_o, 1'b0); m_arready = 1'b1;
      step(); m_arready = 1'b0; chk1("b2b_gnt_t2", data_gnt_o, 1'b0);
      m_rvalid = 1'b1; m_rdata = 32'h1111_1111;
      step(); slave_idle();
      chk1("b2b_gnt_t3", data_gnt_o, 1'b0);
      chk1("b2b_rvalid_t3", data_rvalid_o, 1'b1);
      step(); chk1("b2b_gnt_t4", data_gnt_o, 1'b1);
      step(); data_req_i = 1'b0;
      chk1("b2b_arvalid_t5", m_arvalid, 1'b1);
      m_arready = 1'b1;
      step(); m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h2222_2222;
      step(); slave_idle();
      chk1("b2b_rvalid_t7", data_rvalid_o, 1'b1);
      chk32("b2b_rdata_t7", data_rdata_o, 32'h2222_2222);

      // Reset in the middle of a write.
      step(); data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h0020_0008;
      data_be_i = 4'hF; data_wdata_i = 32'h5555_AAAA; #1;
      chk1("mrst_gnt_t0", data_gnt_o, 1'b1);
      step(); data_req_i = 1'b0;
      chk1("mrst_awvalid_t1", m_awvalid, 1'b1);
      step(); rst = 1'b1;
      step(); rst = 1'b0;
      chk1("mrst_valids_t3", m_awvalid | m_wvalid | m_bready | m_arvalid | m_rready, 1'b0);
      chk1("mrst_rvalid_t3", data_rvalid_o, 1'b0);
      chk1("mrst_err_t3", data_err_o, 1'b0);
      chk32("mrst_rdata_t3", data_rdata_o, 32'h0);
      chk32("mrst_awaddr_t3", m_awaddr, 32'h0);
      chk32("mrst_wdata_t3", m_wdata, 32'h0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk1("mrst_no_resp", data_rvalid_o, 1'b0);
      end
      run_txn(1'b0, 32'h0020_0008, 4'h0, 32'h0);

      // Random mix over mapped and unmapped regions.
      for (int i = 0; i < 40; i++) begin
         r = 3'($urandom_range(0, 5));
         case (r)
            3'd0:    region = 12'h300;
            3'd1:    region = IRAM_REGION;
            3'd2:    region = DRAM_REGION;
            3'd3:    region = PERIPH_REGION;
            default: region = DRAM_REGION;
         endcase
         run_txn(1'($urandom_range(0, 1)), {region, 14'h0, 6'($urandom)},
                 4'($urandom), $urandom);
      end

      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
